// File: rtl/vproc_vreg_reader.sv
// vproc_vreg_reader: walks one vector register group chunk by chunk through a
// register file read port and streams the chunks out over valid/ready. Rev 1.0
`default_nettype none

module vproc_vreg_reader #(
  parameter  int VREG_W = 128,
  parameter  int PORT_W = 32,
  localparam int CHUNKS = VREG_W / PORT_W,
  localparam int CW     = $clog2(CHUNKS),
  localparam int AW     = 5 + CW
) (
  input  logic              clk_i,
  input  logic              async_rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_vreg_i,
  input  logic [1:0]        req_emul_i,
  output logic [AW-1:0]     rd_addr_o,
  input  logic [PORT_W-1:0] rd_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PORT_W-1:0] out_data_o,
  output logic [CW+2:0]     out_idx_o,
  output logic              out_last_o,
  output logic              err_o
);

  localparam int IW = CW + 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] beat_cnt;
  logic [IW-1:0] beat_max;

  logic       accept;
  logic       aligned;
  logic       cap;
  logic [4:0] align_mask;

  assign req_ready_o = (state == IDLE) && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign align_mask  = (5'd1 << req_emul_i) - 5'd1;
  assign aligned     = (req_vreg_i & align_mask) == 5'd0;
  assign cap         = !out_valid_o || out_ready_i;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      beat_max    <= '0;
      rd_addr_o   <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_idx_o   <= '0;
      out_last_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (flush_i) begin
        state       <= IDLE;
        out_valid_o <= 1'b0;
        out_last_o  <= 1'b0;
      end else begin
        // Default drain of a taken beat; a capture below overrides it.
        if (out_valid_o && out_ready_i) begin
          out_valid_o <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (accept) begin
              if (aligned) begin
                rd_addr_o <= {req_vreg_i, {CW{1'b0}}};
                beat_cnt  <= '0;
                beat_max  <= IW'((CHUNKS << req_emul_i) - 1);
                state     <= BUSY;
              end else begin
                err_o <= 1'b1;
              end
            end
          end
          BUSY: begin
            if (cap) begin
              out_data_o  <= rd_data_i;
              out_idx_o   <= beat_cnt;
              out_valid_o <= 1'b1;
              out_last_o  <= (beat_cnt == beat_max);
              beat_cnt    <= beat_cnt + IW'(1);
              // The address stays on the final chunk once the group is done.
              if (beat_cnt == beat_max) begin
                state <= IDLE;
              end else begin
                rd_addr_o <= rd_addr_o + AW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  a_no_accept_busy: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    !(accept && (state == BUSY)));

  a_data_stable: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
    (out_valid_o && !out_ready_i && !flush_i) |=> $stable(out_data_o));

endmodule

`default_nettype wire

// File: tb/tb_vproc_vreg_reader.sv
// tb_vproc_vreg_reader: directed timing cases plus randomized traffic checked
// against a beat-queue reference model of the register group walk. Rev 1.0
`default_nettype none

module tb_vproc_vreg_reader;

  localparam int VREG_W = 128;
  localparam int PORT_W = 32;
  localparam int CHUNKS = VREG_W / PORT_W;
  localparam int CW     = $clog2(CHUNKS);
  localparam int AW     = 5 + CW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              req_valid;
  logic              req_ready;
  logic [4:0]        req_vreg;
  logic [1:0]        req_emul;
  logic [AW-1:0]     rd_addr;
  logic [PORT_W-1:0] rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [PORT_W-1:0] out_data;
  logic [CW+2:0]     out_idx;
  logic              out_last;
  logic              err;

  logic [PORT_W-1:0] mem [0:32*CHUNKS-1];

  typedef struct packed {
    logic [PORT_W-1:0] data;
    logic [CW+2:0]     idx;
    logic              last;
  } beat_t;

  beat_t exp_q[$];
  logic  err_exp;
  int    checks   = 0;
  int    failures = 0;

  always #5 clk = ~clk;

  assign rd_data = mem[rd_addr];

  vproc_vreg_reader #(.VREG_W(VREG_W), .PORT_W(PORT_W)) dut (
    .clk_i        (clk),
    .async_rst_ni (rst_n),
    .flush_i      (flush),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_vreg_i   (req_vreg),
    .req_emul_i   (req_emul),
    .rd_addr_o    (rd_addr),
    .rd_data_i    (rd_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .out_data_o   (out_data),
    .out_idx_o    (out_idx),
    .out_last_o   (out_last),
    .err_o        (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // One clock cycle: observe at the falling edge, then return 1 time unit past the rising edge.
  task automatic cycle();
    beat_t b;
    int    n;
    @(negedge clk);
    if (rst_n) begin
      chk("err", err, err_exp);
      if (flush) chk("ready_during_flush", req_ready, 0);
      if (out_valid && out_ready && !flush) begin
        chk("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("beat_data", out_data, b.data);
          chk("beat_idx", out_idx, b.idx);
          chk("beat_last", out_last, b.last);
        end
      end
      err_exp = 1'b0;
      if (flush) begin
        exp_q.delete();
      end else if (req_valid && req_ready) begin
        n = 1 << req_emul;
        if ((int'(req_vreg) % n) != 0) begin
          err_exp = 1'b1;
        end else begin
          for (int i = 0; i < CHUNKS * n; i++) begin
            b.data = mem[int'(req_vreg) * CHUNKS + i];
            b.idx  = (CW+3)'(i);
            b.last = (i == CHUNKS * n - 1);
            exp_q.push_back(b);
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    req_valid = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (n) cycle();
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic request(input logic [4:0] v, input logic [1:0] e);
    req_valid = 1'b1;
    req_vreg  = v;
    req_emul  = e;
  endtask

  initial begin
    for (int i = 0; i < 32 * CHUNKS; i++) mem[i] = $urandom;
    err_exp   = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_vreg  = '0;
    req_emul  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_req_ready", req_ready, 1);

    // Single register, full throughput: latency and last-beat timing.
    out_ready = 1'b1;
    request(5'd3, 2'd0);
    cycle();
    req_valid = 1'b0;
    chk("t1_c1_addr", rd_addr, 12);
    chk("t1_c1_valid", out_valid, 0);
    chk("t1_c1_ready", req_ready, 0);
    for (int c = 2; c <= 5; c++) begin
      cycle();
      chk("t1_valid", out_valid, 1);
      chk("t1_idx", out_idx, c - 2);
      chk("t1_addr", rd_addr, (c < 5) ? 11 + c : 15);
      chk("t1_req_ready", req_ready, (c == 5) ? 1 : 0);
    end
    drain(3);

    // Two-register group.
    request(5'd4, 2'd1);
    cycle();
    drain(12);

    // Misaligned base.
    request(5'd5, 2'd1);
    cycle();
    req_valid = 1'b0;
    chk("t3_err", err, 1);
    chk("t3_valid", out_valid, 0);
    chk("t3_ready", req_ready, 1);
    cycle();
    chk("t3_err_pulse", err, 0);
    drain(3);

    // Backpressure after beat 1.
    request(5'd0, 2'd0);
    cycle();
    req_valid = 1'b0;
    cycle();
    cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_valid", out_valid, 1);
      chk("t4_idx", out_idx, 1);
      chk("t4_data", out_data, mem[1]);
      chk("t4_addr", rd_addr, 2);
      if (k < 3) cycle();
    end
    drain(8);

    // Flush mid-group with a competing request.
    request(5'd8, 2'd3);
    cycle();
    req_valid = 1'b0;
    repeat (3) cycle();
    chk("t5_idx", out_idx, 2);
    flush = 1'b1;
    request(5'd0, 2'd0);
    #1;
    chk("t5_ready_flush", req_ready, 0);
    cycle();
    flush = 1'b0;
    #1;
    chk("t5_valid_after", out_valid, 0);
    chk("t5_last_after", out_last, 0);
    chk("t5_ready_after", req_ready, 1);
    cycle();
    req_valid = 1'b0;
    chk("t5_new_addr", rd_addr, 0);
    chk("t5_new_busy", req_ready, 0);
    drain(8);

    // Asynchronous reset in the middle of a stream.
    request(5'd16, 2'd2);
    cycle();
    req_valid = 1'b0;
    repeat (4) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid, 0);
    chk("t6_addr", rd_addr, 0);
    chk("t6_data", out_data, 0);
    chk("t6_idx", out_idx, 0);
    chk("t6_last", out_last, 0);
    chk("t6_err", err, 0);
    exp_q.delete();
    err_exp = 1'b0;
    cycle();
    #2;
    rst_n = 1'b1;
    #1;
    chk("t6_ready", req_ready, 1);
    request(5'd2, 2'd1);
    cycle();
    drain(12);

    // Randomized traffic.
    for (int n = 0; n < 2000; n++) begin
      req_valid = ($urandom_range(0, 3) == 0);
      req_vreg  = 5'($urandom);
      req_emul  = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      cycle();
    end
    drain(80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
